// File: rtl/icache_if.sv
// Fetcher and memory-controller signals of the instruction cache, grouped as one bundle.
// The slave modport is the cache's view; master is the fetcher/memory-controller side.
interface icache_if;
  logic        fetch_enable_in;
  logic [31:0] pc_in;
  logic        ic_hit;
  logic        ic_miss_ready;
  logic [31:0] ic_instr;
  logic        ic2mc_valid;
  logic [31:0] ic2mc_addr;
  logic        mc2ic_ready;
  logic [31:0] mc2ic_data;

  modport master (
    output fetch_enable_in, pc_in, mc2ic_ready, mc2ic_data,
    input  ic_hit, ic_miss_ready, ic_instr, ic2mc_valid, ic2mc_addr
  );

  modport slave (
    input  fetch_enable_in, pc_in, mc2ic_ready, mc2ic_data,
    output ic_hit, ic_miss_ready, ic_instr, ic2mc_valid, ic2mc_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped RV32IC instruction cache: 2-byte-aligned fetches, straddling instructions
// assembled across words/lines, whole-line fills from the memory controller on a miss.
module icache #(
  parameter int unsigned INDEX_WIDTH = 4,
  parameter int unsigned BLOCK_WIDTH = 2
) (
  input  logic    clk_in,
  input  logic    rst_in,
  input  logic    rdy_in,
  input  logic    need_flush_in,
  icache_if.slave bus
);
  localparam int unsigned LINES = 1 << INDEX_WIDTH;
  localparam int unsigned WORDS = 1 << BLOCK_WIDTH;
  localparam int unsigned LW    = 30 - BLOCK_WIDTH;
  localparam int unsigned TW    = LW - INDEX_WIDTH;

  typedef enum logic [1:0] {IDLE, FILL, RESP} state_e;

  logic [31:0]            data_q [LINES][WORDS];
  logic [TW-1:0]          tag_q  [LINES];
  logic [LINES-1:0]       valid_q;

  state_e                 state_q, state_d;
  logic [31:1]            miss_pc_q, miss_pc_d;
  logic [LW-1:0]          fill_la_q, fill_la_d;
  logic [BLOCK_WIDTH-1:0] cnt_q, cnt_d;
  logic                   killed_q, killed_d;
  logic                   miss_rdy_q, miss_rdy_d;
  logic [31:0]            instr_q, instr_d;
  logic                   mc_valid_q, mc_valid_d;
  logic [31:0]            mc_addr_q, mc_addr_d;
  logic                   clr_valid, set_valid;

  logic                   wr_fire, fill_done, hit;
  logic [31:1]            look_pc [2];
  logic [29:0]            wa0 [2], wa1 [2];
  logic [LW-1:0]          la0 [2], la1 [2];
  logic                   ok0 [2], ok1 [2], strad [2], full [2];
  logic [31:0]            w0 [2], instr [2];
  logic [15:0]            w1h [2];

  assign wr_fire   = (state_q == FILL) && bus.mc2ic_ready;
  assign fill_done = wr_fire && (&cnt_q);

  // Port 0 looks up pc_in, port 1 the latched miss PC. The word and line completing this
  // cycle are bypassed so the post-fill decision needs no extra cycle.
  always_comb begin
    look_pc[0] = bus.pc_in[31:1];
    look_pc[1] = miss_pc_q;
    for (int unsigned p = 0; p < 2; p++) begin
      wa0[p] = look_pc[p][31:2];
      wa1[p] = wa0[p] + 30'd1;
      la0[p] = wa0[p][29:BLOCK_WIDTH];
      la1[p] = wa1[p][29:BLOCK_WIDTH];
      ok0[p] = (valid_q[la0[p][INDEX_WIDTH-1:0]] &&
                tag_q[la0[p][INDEX_WIDTH-1:0]] == la0[p][LW-1:INDEX_WIDTH]) ||
               (fill_done && la0[p] == fill_la_q);
      ok1[p] = (valid_q[la1[p][INDEX_WIDTH-1:0]] &&
                tag_q[la1[p][INDEX_WIDTH-1:0]] == la1[p][LW-1:INDEX_WIDTH]) ||
               (fill_done && la1[p] == fill_la_q);
      w0[p]  = (wr_fire && wa0[p] == {fill_la_q, cnt_q}) ? bus.mc2ic_data :
               data_q[la0[p][INDEX_WIDTH-1:0]][wa0[p][BLOCK_WIDTH-1:0]];
      w1h[p] = (wr_fire && wa1[p] == {fill_la_q, cnt_q}) ? bus.mc2ic_data[15:0] :
               data_q[la1[p][INDEX_WIDTH-1:0]][wa1[p][BLOCK_WIDTH-1:0]][15:0];
      strad[p] = look_pc[p][1] && (w0[p][17:16] == 2'b11);
      full[p]  = ok0[p] && (!strad[p] || ok1[p]);
      if (!look_pc[p][1]) begin
        instr[p] = (w0[p][1:0] == 2'b11) ? w0[p] : {16'h0000, w0[p][15:0]};
      end else begin
        instr[p] = strad[p] ? {w1h[p], w0[p][31:16]} : {16'h0000, w0[p][31:16]};
      end
    end
  end

  assign hit               = (state_q == IDLE) && bus.fetch_enable_in && full[0] && !need_flush_in;
  assign bus.ic_hit        = hit;
  assign bus.ic_instr      = hit ? instr[0] : instr_q;
  assign bus.ic_miss_ready = miss_rdy_q;
  assign bus.ic2mc_valid   = mc_valid_q;
  assign bus.ic2mc_addr    = mc_addr_q;

  always_comb begin
    state_d    = state_q;
    miss_pc_d  = miss_pc_q;
    fill_la_d  = fill_la_q;
    cnt_d      = cnt_q;
    killed_d   = killed_q;
    miss_rdy_d = 1'b0;
    instr_d    = instr_q;
    mc_valid_d = mc_valid_q;
    mc_addr_d  = mc_addr_q;
    clr_valid  = 1'b0;
    set_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.fetch_enable_in && !full[0] && !need_flush_in) begin
          miss_pc_d  = bus.pc_in[31:1];
          fill_la_d  = ok0[0] ? la1[0] : la0[0];
          cnt_d      = '0;
          killed_d   = 1'b0;
          clr_valid  = 1'b1;
          mc_valid_d = 1'b1;
          mc_addr_d  = {fill_la_d, {BLOCK_WIDTH{1'b0}}, 2'b00};
          state_d    = FILL;
        end
      end
      FILL: begin
        if (need_flush_in) killed_d = 1'b1;
        if (bus.mc2ic_ready) begin
          if (!(&cnt_q)) begin
            cnt_d     = cnt_q + 1'b1;
            mc_addr_d = {fill_la_q, cnt_d, 2'b00};
          end else begin
            set_valid = 1'b1;
            if (killed_d) begin
              mc_valid_d = 1'b0;
              state_d    = IDLE;
            end else if (!full[1]) begin
              fill_la_d = la1[1];
              cnt_d     = '0;
              clr_valid = 1'b1;
              mc_addr_d = {la1[1], {BLOCK_WIDTH{1'b0}}, 2'b00};
            end else begin
              mc_valid_d = 1'b0;
              miss_rdy_d = 1'b1;
              instr_d    = instr[1];
              state_d    = RESP;
            end
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      miss_pc_q  <= '0;
      fill_la_q  <= '0;
      cnt_q      <= '0;
      killed_q   <= 1'b0;
      miss_rdy_q <= 1'b0;
      instr_q    <= '0;
      mc_valid_q <= 1'b0;
      mc_addr_q  <= '0;
      valid_q    <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      miss_pc_q  <= miss_pc_d;
      fill_la_q  <= fill_la_d;
      cnt_q      <= cnt_d;
      killed_q   <= killed_d;
      miss_rdy_q <= miss_rdy_d;
      instr_q    <= instr_d;
      mc_valid_q <= mc_valid_d;
      mc_addr_q  <= mc_addr_d;
      if (set_valid) valid_q[fill_la_q[INDEX_WIDTH-1:0]] <= 1'b1;
      if (clr_valid) valid_q[fill_la_d[INDEX_WIDTH-1:0]] <= 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in) begin
      if (wr_fire)   data_q[fill_la_q[INDEX_WIDTH-1:0]][cnt_q] <= bus.mc2ic_data;
      if (set_valid) tag_q[fill_la_q[INDEX_WIDTH-1:0]] <= fill_la_q[LW-1:INDEX_WIDTH];
    end
  end
endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed scenarios plus random fetches, checked against a memory image
// and a table of resident 16-byte lines (16 lines, direct-mapped on address bits [7:4]).
module tb_icache;
  logic clk = 1'b0;
  logic rst, rdy, flush;
  icache_if bus();

  icache #(.INDEX_WIDTH(4), .BLOCK_WIDTH(2)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .need_flush_in(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [logic [29:0]];
  bit          res_v  [16];
  logic [27:0] res_la [16];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] memw(input logic [29:0] wa);
    if (!mem.exists(wa)) mem[wa] = $urandom;
    return mem[wa];
  endfunction

  function automatic logic [15:0] half(input logic [31:0] a);
    logic [31:0] w;
    w = memw(a[31:2]);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic bit resident(input logic [27:0] la);
    return res_v[la[3:0]] && res_la[la[3:0]] == la;
  endfunction

  function automatic void forget_all();
    foreach (res_v[i]) res_v[i] = 1'b0;
  endfunction

  // Called and returns at posedge+1. The *_at arguments name how many MC words are served
  // before injecting a flush, a 5-cycle rdy freeze, or a reset (-1 = never).
  task automatic fetch(input logic [31:0] pc, input int flush_at, input int freeze_at,
                       input int rst_at);
    logic [15:0] h0, h1;
    logic [31:0] e_instr, a2, req;
    logic [27:0] need [$];
    bit killed;
    int served, t;
    h0 = half(pc);
    a2 = pc + 32'd2;
    h1 = half(a2);
    e_instr = (h0[1:0] == 2'b11) ? {h1, h0} : {16'h0000, h0};
    if (!resident(pc[31:4])) need.push_back(pc[31:4]);
    if (h0[1:0] == 2'b11 && a2[31:4] != pc[31:4] && !resident(a2[31:4])) need.push_back(a2[31:4]);

    bus.fetch_enable_in = 1'b1;
    bus.pc_in = pc;
    #1;
    chk("ic_hit", {31'b0, bus.ic_hit}, {31'b0, need.size() == 0});
    if (need.size() == 0) begin
      chk("hit_instr", bus.ic_instr, e_instr);
      chk("hit_no_req", {31'b0, bus.ic2mc_valid}, 32'd0);
      @(posedge clk); #1;
      bus.fetch_enable_in = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.fetch_enable_in = 1'b0;
    killed = 1'b0;
    served = 0;
    foreach (need[k]) begin
      if (killed) break;
      for (int w = 0; w < 4; w++) begin
        req = {need[k], w[1:0], 2'b00};
        if (served == rst_at) begin
          rst = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          chk("rst_req_drop", {31'b0, bus.ic2mc_valid}, 32'd0);
          chk("rst_no_rdy", {31'b0, bus.ic_miss_ready}, 32'd0);
          forget_all();
          return;
        end
        if (served == flush_at) begin
          flush = 1'b1;
          @(posedge clk); #1;
          flush = 1'b0;
          killed = 1'b1;
        end
        if (served == freeze_at) begin
          rdy = 1'b0;
          repeat (5) begin
            @(posedge clk); #1;
            chk("freeze_addr", bus.ic2mc_addr, req);
            chk("freeze_valid", {31'b0, bus.ic2mc_valid}, 32'd1);
          end
          rdy = 1'b1;
        end
        t = 0;
        while (!bus.ic2mc_valid && t < 20) begin
          @(posedge clk); #1;
          t++;
        end
        chk("mc_valid", {31'b0, bus.ic2mc_valid}, 32'd1);
        chk("mc_addr", bus.ic2mc_addr, req);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        bus.mc2ic_ready = 1'b1;
        bus.mc2ic_data = memw(req[31:2]);
        @(posedge clk); #1;
        bus.mc2ic_ready = 1'b0;
        bus.mc2ic_data = $urandom;
        served++;
      end
      res_v[need[k][3:0]] = 1'b1;
      res_la[need[k][3:0]] = need[k];
    end
    if (killed) begin
      repeat (3) begin
        chk("kill_no_rdy", {31'b0, bus.ic_miss_ready}, 32'd0);
        chk("kill_no_req", {31'b0, bus.ic2mc_valid}, 32'd0);
        @(posedge clk); #1;
      end
    end else begin
      chk("miss_rdy", {31'b0, bus.ic_miss_ready}, 32'd1);
      chk("miss_instr", bus.ic_instr, e_instr);
      chk("resp_no_req", {31'b0, bus.ic2mc_valid}, 32'd0);
      @(posedge clk); #1;
      chk("rdy_pulse_end", {31'b0, bus.ic_miss_ready}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] r, pcr;
    rst = 1'b1;
    rdy = 1'b1;
    flush = 1'b0;
    bus.fetch_enable_in = 1'b0;
    bus.pc_in = '0;
    bus.mc2ic_ready = 1'b0;
    bus.mc2ic_data = '0;
    forget_all();

    r = $urandom;
    mem[30'h0] = r | 32'h0000_0003;
    mem[30'h4] = 32'h0001_0001;
    mem[30'h7] = {16'h0513, r[15:0]};
    mem[30'h8] = {r[31:16], 16'h0000};
    mem[30'h3FFF_FFFF] = r | 32'h0003_0000;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, bus.ic2mc_valid}, 32'd0);
    chk("rst_addr", bus.ic2mc_addr, 32'd0);
    chk("rst_rdy", {31'b0, bus.ic_miss_ready}, 32'd0);
    chk("rst_instr", bus.ic_instr, 32'd0);
    rst = 1'b0;

    fetch(32'h0000_0000, -1, -1, -1);
    fetch(32'h0000_0004, -1, -1, -1);
    fetch(32'h0000_0010, -1, -1, -1);
    fetch(32'h0000_0012, -1, -1, -1);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    forget_all();
    fetch(32'h0000_001E, -1, -1, -1);

    fetch(32'h0000_0040, 2, -1, -1);
    fetch(32'h0000_0040, -1, -1, -1);

    fetch(32'h0000_0000, -1, -1, -1);
    fetch(32'h0000_0100, -1, -1, -1);
    fetch(32'h0000_0000, -1, -1, -1);

    fetch(32'h0000_0200, -1, 1, -1);
    fetch(32'h0000_0300, -1, -1, 2);
    fetch(32'h0000_0004, -1, -1, -1);

    fetch(32'hFFFF_FFFE, -1, -1, -1);
    fetch(32'hFFFF_FFFE, -1, -1, -1);

    for (int i = 0; i < 60; i++) begin
      pcr = $urandom_range(0, 32'h3FF) & 32'hFFFF_FFFE;
      fetch(pcr, -1, -1, -1);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
